// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: synchronous FIFO with programmable thresholds, optional FWFT reads, flush and sticky error flags
module sync_fifo_ext #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C = AE_LEVEL[AW:0];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic rd_ok, wr_ok;
    assign full = count == DEPTH_C;
    assign empty = count == '0;
    assign almost_full = count >= AF_C;
    assign almost_empty = count <= AE_C;
    // a pop frees the slot a same-cycle write needs, so a full FIFO can still accept a write
    assign rd_ok = !flush && rd_en && !empty;
    assign wr_ok = !flush && wr_en && (!full || rd_ok);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow <= (overflow && !clr_err) || (!flush && wr_en && !wr_ok);
            underflow <= (underflow && !clr_err) || (!flush && rd_en && empty);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end
    if (FWFT != 0) begin : g_fwft
        assign dout = mem[rd_ptr];
        assign dout_valid = !empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= rd_ok;
                if (rd_ok) dout <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext: directed plus random checks of standard and FWFT instances against a queue model
module tb_sync_fifo_ext;
    localparam int W = 8, D = 16, AF = D - 2, AE = 2;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout_s, dout_f;
    logic dv_s, dv_f, full_s, full_f, empty_s, empty_f, af_s, af_f, ae_s, ae_f;
    logic ov_s, ov_f, un_s, un_f;
    logic [4:0] count_s, count_f;
    int checks = 0, errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic m_dv, m_ov, m_un;

    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout_s), .dout_valid(dv_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s), .overflow(ov_s), .underflow(un_s));
    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout_f), .dout_valid(dv_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f), .overflow(ov_f), .underflow(un_f));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model(input logic w, input logic r, input logic f, input logic c, input logic [W-1:0] d);
        int n;
        logic rd_ok, wr_ok;
        n = q.size();
        rd_ok = !f && r && n != 0;
        wr_ok = !f && w && (n != D || rd_ok);
        m_ov = (m_ov && !c) || (!f && w && !wr_ok);
        m_un = (m_un && !c) || (!f && r && n == 0);
        m_dv = rd_ok;
        if (f) q.delete();
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count_s", 32'(count_s), 32'(n));
        chk("count_f", 32'(count_f), 32'(n));
        chk("full_s", 32'(full_s), 32'(n == D));
        chk("full_f", 32'(full_f), 32'(n == D));
        chk("empty_s", 32'(empty_s), 32'(n == 0));
        chk("empty_f", 32'(empty_f), 32'(n == 0));
        chk("af_s", 32'(af_s), 32'(n >= AF));
        chk("af_f", 32'(af_f), 32'(n >= AF));
        chk("ae_s", 32'(ae_s), 32'(n <= AE));
        chk("ae_f", 32'(ae_f), 32'(n <= AE));
        chk("ov_s", 32'(ov_s), 32'(m_ov));
        chk("ov_f", 32'(ov_f), 32'(m_ov));
        chk("un_s", 32'(un_s), 32'(m_un));
        chk("un_f", 32'(un_f), 32'(m_un));
        chk("dv_s", 32'(dv_s), 32'(m_dv));
        chk("dout_s", 32'(dout_s), 32'(m_dout));
        chk("dv_f", 32'(dv_f), 32'(n != 0));
        if (n != 0) chk("dout_f", 32'(dout_f), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic r, input logic f, input logic c, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        flush = f;
        clr_err = c;
        din = d;
        @(posedge clk);
        model(w, r, f, c, d);
        #1 check_all();
    endtask

    initial begin
        logic w, r, f, c;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        for (int i = 1; i <= 17; i++) step(1, 0, 0, 0, W'(i));
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, W'(8'h40 + i));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, W'(8'h80 + i));
        for (int i = 0; i < 13; i++) step(1, 0, 0, 0, W'(8'hC0 + i));
        step(1, 1, 0, 0, 8'hAA);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, 8'h77);
        step(0, 1, 0, 0, '0);
        step(1, 0, 0, 0, 8'h5A);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, W'(8'h10 + i));
        step(1, 0, 1, 0, 8'hEE);
        step(1, 0, 0, 0, 8'h33);
        step(0, 1, 0, 0, '0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, W'(8'h20 + i));
        wr_en = 1'b1;
        rd_en = 1'b1;
        din = 8'h99;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        for (int i = 0; i < 600; i++) begin
            w = ((i / 60) % 2) != 0 ? ($urandom % 4) != 0 : ($urandom % 4) == 0;
            r = ($urandom % 2) != 0;
            f = ($urandom % 50) == 0;
            c = ($urandom % 16) == 0;
            step(w, r, f, c, W'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
